uhf_rx_hdlc_deframer: RTL

//  Receive-side counterpart of the UHF TX data path. Takes serial NRZI bits from the UHF

---
 rtl/uhf_rx_hdlc_deframer.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uhf_rx_hdlc_deframer.sv
// UHF receive HDLC deframer.
// Serial NRZI line bits are decoded, de-stuffed and assembled into LSB-first bytes
// between HDLC flags. Each byte is written to LSRAM through a small APB master.
// The CRC-16/X.25 residue is checked over the whole frame, and every completed frame
// is reported through a ready/ack handshake.
module uhf_rx_hdlc_deframer #(
   parameter int unsigned MIN_LEN = 3,
   parameter logic [15:0] CRC_RES = 16'hF0B8
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        i_en_rx,
   input  logic        i_rx_bit_en,
   input  logic        i_rx_data,
   input  logic [12:0] i_base_addr,
   input  logic [12:0] i_max_len,
   input  logic        i_frame_ack,
   input  logic        i_clear_err,
   output logic [19:0] PADDR_SRAM,
   output logic        PSEL_SRAM,
   output logic        PENABLE_SRAM,
   output logic        PWRITE_SRAM,
   output logic [7:0]  PWDATA_SRAM,
   input  logic        PREADY_SRAM,
   output logic        o_frame_ready,
   output logic        o_crc_ok,
   output logic [12:0] o_frame_len,
   output logic [15:0] o_rx_fcs,
   output logic        o_busy,
   output logic        o_overflow,
   output logic        o_abort
);

   localparam logic [12:0] MIN_LEN_C = 13'(MIN_LEN);

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Encoding doubles as the registered {PSEL, PENABLE} pair.
   typedef enum logic [1:0] {
      AP_IDLE   = 2'b00,
      AP_SETUP  = 2'b10,
      AP_ACCESS = 2'b11
   } apb_t;

   // Byte-wise CRC-16/X.25 update (reflected polynomial 0x8408, no final xor).
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] c;
      c = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ 16'h8408;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   state_t      r_state;
   state_t      w_state_case;
   state_t      w_state_nxt;
   apb_t        r_apb_st;
   apb_t        w_apb_nxt;

   logic        r_nrzi_prev;
   logic [2:0]  r_ones;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_shreg;
   logic [12:0] r_len;
   logic [15:0] r_crc;
   logic [7:0]  r_last;
   logic [7:0]  r_prev;
   logic        r_pending;
   logic [7:0]  r_pend_data;
   logic [12:0] r_pend_addr;

   logic        r_frame_ready;
   logic        r_crc_ok;
   logic [12:0] r_frame_len;
   logic [15:0] r_rx_fcs;
   logic        r_busy;
   logic        r_overflow;
   logic        r_abort;

   logic        w_bit_ev;
   logic        w_d;
   logic        w_assemble;
   logic        w_flag_ev;
   logic        w_stuff;
   logic        w_abort_ev;
   logic        w_shift;
   logic [7:0]  w_byte_val;
   logic        w_byte_done;
   logic        w_ovf_pend;
   logic        w_ovf_len;
   logic        w_byte_ok;
   logic        w_frame_close;
   logic        w_restart;
   logic        w_busy_nxt;
   logic        w_ready_nxt;
   logic        w_latch;

   // Line-bit event decode: NRZI, stuffing, flag, abort and byte completion.
   always_comb begin
      w_bit_ev      = i_rx_bit_en & i_en_rx;
      w_d           = (i_rx_data == r_nrzi_prev);
      w_assemble    = w_bit_ev && ((r_state == ST_SYNC) || (r_state == ST_DATA));
      w_flag_ev     = w_bit_ev && !w_d && (r_ones == 3'd6);
      w_stuff       = !w_d && (r_ones == 3'd5);
      w_abort_ev    = w_assemble && w_d && (r_ones == 3'd6);
      w_shift       = w_assemble && !w_stuff && !w_flag_ev && !w_abort_ev;
      w_byte_val    = {w_d, r_shreg[7:1]};
      w_byte_done   = w_shift && (r_bitcnt == 3'd7);
      w_ovf_pend    = w_byte_done && r_pending;
      w_ovf_len     = w_byte_done && (r_len == i_max_len);
      w_byte_ok     = w_byte_done && !w_ovf_pend && !w_ovf_len;
      // A closing flag must sit on a byte boundary and end a long enough frame.
      w_frame_close = w_assemble && w_flag_ev && (r_bitcnt == 3'd7) && (r_len >= MIN_LEN_C);
      // Any other flag seen while hunting or assembling starts a fresh frame.
      w_restart     = w_flag_ev && !w_frame_close &&
                      ((r_state == ST_HUNT) || (r_state == ST_SYNC) || (r_state == ST_DATA));
   end

   // Frame FSM state register.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame FSM next-state logic; receiver disable forces HUNT except when holding a frame.
   always_comb begin
      w_state_case = r_state;
      case (r_state)
         ST_HUNT: begin
            if (w_flag_ev) begin
               w_state_case = ST_SYNC;
            end else begin
               w_state_case = ST_HUNT;
            end
         end
         ST_SYNC, ST_DATA: begin
            if (w_abort_ev) begin
               w_state_case = ST_HUNT;
            end else if (w_flag_ev) begin
               w_state_case = w_frame_close ? ST_DRAIN : ST_SYNC;
            end else if (w_byte_done) begin
               w_state_case = (w_ovf_pend || w_ovf_len) ? ST_HUNT : ST_DATA;
            end else begin
               w_state_case = r_state;
            end
         end
         ST_DRAIN: begin
            if (!r_pending) begin
               w_state_case = ST_DONE;
            end else begin
               w_state_case = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (i_frame_ack) begin
               w_state_case = ST_HUNT;
            end else begin
               w_state_case = ST_DONE;
            end
         end
         default: w_state_case = ST_HUNT;
      endcase
      w_state_nxt = (!i_en_rx && (r_state != ST_DONE)) ? ST_HUNT : w_state_case;
   end

   // Frame FSM outputs, computed from the next state so they can be registered.
   always_comb begin
      w_busy_nxt  = (w_state_nxt == ST_DATA) || (w_state_nxt == ST_DRAIN);
      w_ready_nxt = (w_state_nxt == ST_DONE);
      w_latch     = (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
   end

   // Bit datapath: NRZI history, ones run, byte assembly, length and CRC.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_nrzi_prev <= 1'b0;
         r_ones      <= 3'd0;
         r_bitcnt    <= 3'd0;
         r_shreg     <= 8'h00;
         r_len       <= 13'd0;
         r_crc       <= 16'hFFFF;
         r_last      <= 8'h00;
         r_prev      <= 8'h00;
         r_pend_data <= 8'h00;
         r_pend_addr <= 13'd0;
      end else begin
         if (w_bit_ev) begin
            r_nrzi_prev <= i_rx_data;
            if (w_d) begin
               r_ones <= (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;
            end else begin
               r_ones <= 3'd0;
            end
         end
         if (w_restart) begin
            r_bitcnt <= 3'd0;
            r_len    <= 13'd0;
            r_crc    <= 16'hFFFF;
         end else if (w_shift) begin
            r_shreg <= w_byte_val;
            if (w_byte_done) begin
               r_bitcnt <= 3'd0;
               if (w_byte_ok) begin
                  r_crc       <= crc16_byte(r_crc, w_byte_val);
                  r_len       <= r_len + 13'd1;
                  r_prev      <= r_last;
                  r_last      <= w_byte_val;
                  r_pend_data <= w_byte_val;
                  r_pend_addr <= i_base_addr + r_len;
               end
            end else begin
               r_bitcnt <= r_bitcnt + 3'd1;
            end
         end
      end
   end

   // Frame report and sticky error flags; a set event beats a same-cycle clear.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_busy        <= 1'b0;
         r_frame_ready <= 1'b0;
         r_frame_len   <= 13'd0;
         r_crc_ok      <= 1'b0;
         r_rx_fcs      <= 16'h0000;
         r_overflow    <= 1'b0;
         r_abort       <= 1'b0;
      end else begin
         r_busy        <= w_busy_nxt;
         r_frame_ready <= w_ready_nxt;
         if (w_latch) begin
            r_frame_len <= r_len;
            r_crc_ok    <= (r_crc == CRC_RES);
            r_rx_fcs    <= {r_last, r_prev};
         end
         if (w_ovf_pend || w_ovf_len) begin
            r_overflow <= 1'b1;
         end else if (i_clear_err) begin
            r_overflow <= 1'b0;
         end
         if (w_abort_ev) begin
            r_abort <= 1'b1;
         end else if (i_clear_err) begin
            r_abort <= 1'b0;
         end
      end
   end

   // APB writer state register.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_apb_st <= AP_IDLE;
      end else begin
         r_apb_st <= w_apb_nxt;
      end
   end

   // APB writer next state: setup, then access until the LSRAM is ready.
   always_comb begin
      w_apb_nxt = r_apb_st;
      case (r_apb_st)
         AP_IDLE: begin
            if (r_pending) begin
               w_apb_nxt = AP_SETUP;
            end else begin
               w_apb_nxt = AP_IDLE;
            end
         end
         AP_SETUP: w_apb_nxt = AP_ACCESS;
         AP_ACCESS: begin
            if (PREADY_SRAM) begin
               w_apb_nxt = AP_IDLE;
            end else begin
               w_apb_nxt = AP_ACCESS;
            end
         end
         default: w_apb_nxt = AP_IDLE;
      endcase
   end

   // Pending-byte flag: set by a completed byte, cleared when its write finishes.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_pending <= 1'b0;
      end else if (w_byte_ok) begin
         r_pending <= 1'b1;
      end else if ((r_apb_st == AP_ACCESS) && PREADY_SRAM) begin
         r_pending <= 1'b0;
      end
   end

   // APB outputs come straight from registers; pending data is stable during a transfer.
   assign PSEL_SRAM     = r_apb_st[1];
   assign PENABLE_SRAM  = r_apb_st[0];
   assign PWRITE_SRAM   = r_apb_st[1];
   assign PADDR_SRAM    = {7'b0000000, r_pend_addr};
   assign PWDATA_SRAM   = r_pend_data;

   assign o_frame_ready = r_frame_ready;
   assign o_crc_ok      = r_crc_ok;
   assign o_frame_len   = r_frame_len;
   assign o_rx_fcs      = r_rx_fcs;
   assign o_busy        = r_busy;
   assign o_overflow    = r_overflow;
   assign o_abort       = r_abort;

endmodule
